// File: rtl/pwm_fade_ctrl.sv
// pwm_fade_ctrl: ramps PWM duty toward a target in fixed steps at frame boundaries,
// either as a one-shot fade or as continuous breathing between 0 and the target.
module pwm_fade_ctrl #(
   parameter int unsigned PERIOD = 1000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        cfg_valid,
   output logic        cfg_ready,
   input  logic        cfg_mode,
   input  logic [31:0] cfg_target,
   input  logic [31:0] cfg_step,
   input  logic [15:0] cfg_dwell,
   input  logic        abort,
   output logic [31:0] duty,
   output logic [31:0] period,
   output logic        frame_tick,
   output logic        busy,
   output logic        done
);
   localparam logic [31:0] P = 32'(PERIOD);
   typedef enum logic [1:0] {IDLE, UP, DOWN} state_t;
   state_t      state_q;
   logic [31:0] frame_cnt_q, frame_cnt_d, duty_q, target_q, step_q;
   logic [15:0] dwell_q, dwell_cnt_q;
   logic        mode_q, tick_q, ready_q, busy_q, done_q;
   logic [31:0] tgt_c, up_d, floor_c, down_d;
   logic [32:0] up_sum, down_lim;
   logic        step_now;
   assign frame_cnt_d = (frame_cnt_q == P) ? 32'd0 : frame_cnt_q + 32'd1;
   assign tgt_c       = (cfg_target > P) ? P : cfg_target;
   assign up_sum      = {1'b0, duty_q} + {1'b0, step_q};
   assign up_d        = (up_sum > {1'b0, target_q}) ? target_q : up_sum[31:0];
   // Breathing always descends to 0; a one-shot fade stops at its target.
   assign floor_c     = mode_q ? 32'd0 : target_q;
   assign down_lim    = {1'b0, floor_c} + {1'b0, step_q};
   assign down_d      = ({1'b0, duty_q} > down_lim) ? duty_q - step_q : floor_c;
   assign step_now    = tick_q && (dwell_cnt_q == dwell_q - 16'd1);
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= IDLE;
         frame_cnt_q <= 32'd0;
         tick_q      <= 1'b0;
         duty_q      <= 32'd0;
         target_q    <= 32'd0;
         step_q      <= 32'd1;
         dwell_q     <= 16'd1;
         dwell_cnt_q <= 16'd0;
         mode_q      <= 1'b0;
         ready_q     <= 1'b1;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         frame_cnt_q <= frame_cnt_d;
         tick_q      <= frame_cnt_d == P;
         done_q      <= 1'b0;
         if (state_q == IDLE) begin
            if (cfg_valid) begin
               mode_q      <= cfg_mode;
               target_q    <= tgt_c;
               step_q      <= (cfg_step == 32'd0) ? 32'd1 : cfg_step;
               dwell_q     <= (cfg_dwell == 16'd0) ? 16'd1 : cfg_dwell;
               dwell_cnt_q <= 16'd0;
               if (duty_q < tgt_c || duty_q > tgt_c || cfg_mode) begin
                  state_q <= (duty_q < tgt_c) ? UP : DOWN;
                  ready_q <= 1'b0;
                  busy_q  <= 1'b1;
               end else
                  done_q <= 1'b1;
            end
         end else if (abort) begin
            state_q <= IDLE;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
         end else if (step_now) begin
            dwell_cnt_q <= 16'd0;
            duty_q      <= (state_q == UP) ? up_d : down_d;
            if ((state_q == UP) ? (up_d == target_q) : (down_d == floor_c)) begin
               if (mode_q)
                  state_q <= (state_q == UP) ? DOWN : UP;
               else begin
                  state_q <= IDLE;
                  ready_q <= 1'b1;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
               end
            end
         end else if (tick_q)
            dwell_cnt_q <= dwell_cnt_q + 16'd1;
      end
   end
   assign cfg_ready  = ready_q;
   assign busy       = busy_q;
   assign done       = done_q;
   assign duty       = duty_q;
   assign frame_tick = tick_q;
   assign period     = P;
endmodule

// File: doc/pwm_fade_ctrl.md
# pwm_fade_ctrl

Sequencer that generates the `duty`/`period` pair for one PWM generator instance, ramping duty to a target value in fixed steps at PWM-frame boundaries. It supports two modes: one-shot fade to a level, and continuous breathing between 0 and a level. A simple valid/ready handshake accepts commands. It sits between the LED/effect control logic and the PWM output stage.

## Interface

**Parameters**
- `PERIOD`, default 1000: value driven on `period`. One PWM frame is PERIOD+1 clk cycles.

**Ports**
- `clk` in 1: clock.
- `rst` in 1: reset, asynchronous, active-low.
- `cfg_valid` in 1: command present.
- `cfg_ready` out 1: block can accept a command (high exactly in IDLE).
- `cfg_mode` in 1: 0 = one-shot fade, 1 = breathe.
- `cfg_target` in 32: target duty.
- `cfg_step` in 32: duty increment/decrement per step.
- `cfg_dwell` in 16: frames per step.
- `abort` in 1: stop an active command.
- `duty` out 32: duty to the PWM generator.
- `period` out 32: constant PERIOD.
- `frame_tick` out 1: high during the last cycle of each frame.
- `busy` out 1: command in progress.
- `done` out 1: one-cycle pulse when a one-shot fade completes.

## Operation

**Frame counter**
- `frame_cnt` counts 0..PERIOD, wraps to 0, and runs freely from reset.
- `frame_tick` = (`frame_cnt` == PERIOD), so it fires every PERIOD+1 cycles.

**Command acceptance and input rules**
- A command is accepted on a clk edge with `cfg_valid` && `cfg_ready`. Mode, target, step and dwell are latched at that edge.
- `cfg_valid` while not in IDLE is ignored; nothing is latched.
- Target clamp: latched target = min(`cfg_target`, PERIOD).
- `cfg_step` = 0 is treated as 1. `cfg_dwell` = 0 is treated as 1.
- `dwell_cnt` is cleared at acceptance.

**States: IDLE, UP, DOWN**
- IDLE → UP if accepted duty < target.
- IDLE → DOWN if accepted duty > target, or in breathe mode if duty > target.
- Duty == target at acceptance:
  - One-shot: stay in IDLE, pulse `done` the next cycle, `busy` stays 0.
  - Breathe: go to DOWN, or stay in UP/DOWN at 0 when target = 0 (see breathe rules).

**Step rule**
- In UP/DOWN, on each `frame_tick`, `dwell_cnt` increments.
- When `dwell_cnt` == dwell−1, a step occurs and `dwell_cnt` clears.
- UP step: duty ← min(duty+step, target), computed 33-bit with no wrap.
- DOWN step: duty ← (duty > floor+step) ? duty−step : floor.
  - floor = target in one-shot mode.
  - floor = 0 in breathe mode.

**One-shot mode**
- The step that makes duty == target returns the block to IDLE.
- `done` = 1 in the same cycle the final duty value appears.

**Breathe mode**
- UP ends at target, then switches to DOWN.
- DOWN ends at 0, then switches to UP. This repeats indefinitely, and `done` is never asserted.
- Target = 0: duty holds at 0 and `busy` stays 1 until `abort`.

**Abort**
- `abort` in UP/DOWN: next edge goes to IDLE, duty holds its current value, no `done`.
- `abort` in IDLE is ignored. If `abort` and `cfg_valid` are both high in IDLE, the command is accepted.

## Timing

**Reset values**
- `duty` = 0, `period` = PERIOD, `cfg_ready` = 1, `busy` = 0, `done` = 0, `frame_cnt` = 0, `frame_tick` = 0.
- Reset asserted mid-command forces all of these immediately.

**Handshake and status latency**
- `cfg_ready` falls and `busy` rises the cycle after acceptance.
- `busy` falls, and `cfg_ready` rises, in the same cycle `done` pulses or the cycle after `abort`.

**Output registering**
- All outputs are registered.
- `duty` changes only on the edge that ends a `frame_tick` cycle, or never when idle. The PWM generator therefore sees stable duty for whole frames.

**Step timing**
- The first step occurs at the dwell-th `frame_tick` after acceptance. The partial first frame counts as one.
- Later steps occur every dwell frames.

## Test plan

All scenarios use PERIOD = 9, i.e. 10-cycle frames.

1. **Reset:** release reset → `duty`=0, `period`=9, `cfg_ready`=1, `busy`=0. `frame_tick` is high every 10th cycle, first at cycle 9.
2. **One-shot up:** target 5, step 2, dwell 1 → duty 0→2→4→5 on three consecutive frame ticks. `done` is pulsed with duty=5, then `busy`=0 and `cfg_ready`=1.
3. **One-shot down:** from duty 5, target 0, step 3, dwell 2 → duty 5→2→0, one step every 2 frames, then `done`. Re-issuing target 0 → `done` the cycle after acceptance, `busy` never 1.
4. **Clamp and zero step:**
   - target 50, step 4 → duty 4, 8, 9, then `done`.
   - step 0, target 3 from 0 → duty 1, 2, 3.
5. **Breathe and abort:** breathe, target 4, step 2, dwell 1 → duty 0,2,4,2,0,2,4… with no `done`. `abort` while duty=2 → IDLE next edge, duty stays 2, no `done`.
6. **Busy rejection:** `cfg_valid` with a new target while `busy` → ignored, the original ramp completes unchanged. Async reset during a ramp → `duty`=0 and `busy`=0 immediately.
